// File: rtl/seg_tub_pkg.sv
// Shared constants for the seven-segment tub scanner: digit count default,
// hex-to-segment table and scan FSM encoding.
package seg_tub_pkg;

  localparam int NUM_DIGITS_DEF = 8;

  // {a,b,c,d,e,f,g}, active-high; entry 0 is the rightmost element.
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
    7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to {a..g} segment pattern.
module seg_hex_decoder
  import seg_tub_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_LUT[hex_i];

endmodule

// File: rtl/seg_tub_scanner.sv
// Time-multiplexes NUM_DIGITS hex digits onto a shared segment bus, advancing on
// synchronized tub_clk rises with a blank gap between digits and frame-aligned updates.
module seg_tub_scanner
  import seg_tub_pkg::*;
#(
  parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tub_clk,
  input  logic                    disp_en,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   tub_sel,
  output logic [7:0]              tub_seg,
  output logic                    frame_done
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLANK_CYCLES - 1);

  logic s1_q, s2_q, s3_q;
  logic tick;

  logic [4*NUM_DIGITS-1:0] shd_dig_q, act_dig_q;
  logic [NUM_DIGITS-1:0]   shd_blk_q, act_blk_q, shd_dp_q, act_dp_q;
  logic                    pend_q;

  scan_state_e           state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic [7:0]            seg_q, seg_d;
  logic                  fd_q, fd_d;
  logic                  wrap;

  logic [6:0]            dec;
  logic [NUM_DIGITS-1:0] sel_show;
  logic [7:0]            seg_show;

  // tub_clk is asynchronous data: two sync stages plus a history flop for the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= tub_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick = s2_q & ~s3_q;

  seg_hex_decoder u_dec (
    .hex_i (act_dig_q[{idx_q, 2'b00} +: 4]),
    .seg_o (dec)
  );

  assign sel_show = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q;
  assign seg_show = act_blk_q[idx_q] ? 8'h00 : {dec, act_dp_q[idx_q]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sel_d   = '0;
    seg_d   = '0;
    fd_d    = 1'b0;
    wrap    = 1'b0;
    if (!disp_en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_BLANK: begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            sel_d   = sel_show;
            seg_d   = seg_show;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (tick) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              fd_d  = 1'b1;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            sel_d = sel_show;
            seg_d = seg_show;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      seg_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  // A load coinciding with the wrap bypasses the shadow so it is not deferred a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_dig_q <= '0;
      shd_blk_q <= '0;
      shd_dp_q  <= '0;
      act_dig_q <= '0;
      act_blk_q <= '0;
      act_dp_q  <= '0;
      pend_q    <= 1'b0;
    end else if (load) begin
      if (wrap) begin
        act_dig_q <= digits;
        act_blk_q <= blank_mask;
        act_dp_q  <= dp_mask;
        pend_q    <= 1'b0;
      end else begin
        shd_dig_q <= digits;
        shd_blk_q <= blank_mask;
        shd_dp_q  <= dp_mask;
        pend_q    <= 1'b1;
      end
    end else if (pend_q && (wrap || state_q == ST_IDLE)) begin
      act_dig_q <= shd_dig_q;
      act_blk_q <= shd_blk_q;
      act_dp_q  <= shd_dp_q;
      pend_q    <= 1'b0;
    end
  end

  assign tub_sel    = sel_q;
  assign tub_seg    = seg_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_tub_scanner.sv
// Scoreboarded bench: stimulus queues the expected {tub_sel,tub_seg} of each digit
// it causes to appear; a monitor pops and compares whenever a new digit lights up.
module tb_seg_tub_scanner;

  logic        clk = 1'b0;
  logic        rst_n, tub_clk, disp_en, load;
  logic [31:0] digits;
  logic [7:0]  blank_mask, dp_mask;
  logic [7:0]  tub_sel, tub_seg;
  logic        frame_done;

  int          nvec = 0;
  int          nerr = 0;
  int          fd_cnt = 0;
  logic [15:0] expq[$];
  logic [7:0]  prev_sel = 8'h00;

  seg_tub_scanner #(.NUM_DIGITS(8), .BLANK_CYCLES(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tub_clk    (tub_clk),
    .disp_en    (disp_en),
    .digits     (digits),
    .blank_mask (blank_mask),
    .dp_mask    (dp_mask),
    .load       (load),
    .tub_sel    (tub_sel),
    .tub_seg    (tub_seg),
    .frame_done (frame_done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: invariants every cycle, scoreboard pop on each new digit.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      chk("onehot_sel", {31'd0, $onehot0(tub_sel)}, 32'd1);
      if (tub_sel == 8'h00) chk("dark_seg", {24'd0, tub_seg}, 32'd0);
      if (frame_done) fd_cnt++;
      if (tub_sel != 8'h00 && prev_sel == 8'h00) begin
        if (expq.size() == 0) chk("unexpected_digit", {16'd0, tub_sel, tub_seg}, 32'd0);
        else chk("digit", {16'd0, tub_sel, tub_seg}, {16'd0, expq.pop_front()});
      end
    end
    prev_sel = tub_sel;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Bus is scribbled after the pulse so only the captured copy can be displayed.
  task automatic do_load(input logic [31:0] d, input logic [7:0] bm, input logic [7:0] dm);
    digits = d; blank_mask = bm; dp_mask = dm; load = 1'b1;
    cyc(1);
    load = 1'b0; digits = 32'hDEADBEEF; blank_mask = 8'h00; dp_mask = 8'h00;
  endtask

  task automatic enable_and_wait(input logic [7:0] sel, input logic [7:0] seg);
    expq.push_back({sel, seg});
    disp_en = 1'b1;
    cyc(16);
    chk("en_blank", {24'd0, tub_sel}, 32'd0);
    cyc(1);
    chk("en_first_sel", {24'd0, tub_sel}, {24'd0, sel});
  endtask

  // Rise sampled at edge N: still lit after N+1, dark from N+2, next digit at N+18.
  task automatic tick(input logic [7:0] sel, input logic [7:0] seg, input logic fd);
    expq.push_back({sel, seg});
    tub_clk = 1'b1;
    cyc(2);
    chk("hold_lit", {31'd0, tub_sel != 8'h00}, 32'd1);
    tub_clk = 1'b0;
    cyc(1);
    chk("gap_sel", {24'd0, tub_sel}, 32'd0);
    chk("gap_seg", {24'd0, tub_seg}, 32'd0);
    chk("frame_done", {31'd0, frame_done}, {31'd0, fd});
    cyc(15);
    chk("gap_end", {24'd0, tub_sel}, 32'd0);
    cyc(1);
    chk("next_sel", {24'd0, tub_sel}, {24'd0, sel});
  endtask

  initial begin
    rst_n = 1'b0; tub_clk = 1'b0; disp_en = 1'b0; load = 1'b0;
    digits = 32'h0; blank_mask = 8'h00; dp_mask = 8'h00;
    cyc(3);
    chk("rst_sel", {24'd0, tub_sel}, 32'd0);
    chk("rst_seg", {24'd0, tub_seg}, 32'd0);
    chk("rst_fd", {31'd0, frame_done}, 32'd0);
    rst_n = 1'b1;
    cyc(2);
    chk("idle_sel", {24'd0, tub_sel}, 32'd0);

    // First frame 76543210, loaded while idle.
    do_load(32'h76543210, 8'h00, 8'h00);
    cyc(1);
    enable_and_wait(8'h01, 8'hFC);
    tick(8'h02, 8'h60, 1'b0);
    do_load(32'hFEDCBA98, 8'h00, 8'h00);
    tick(8'h04, 8'hDA, 1'b0);
    tick(8'h08, 8'hF2, 1'b0);
    tick(8'h10, 8'h66, 1'b0);
    tick(8'h20, 8'hB6, 1'b0);
    tick(8'h40, 8'hBE, 1'b0);
    tick(8'h80, 8'hE0, 1'b0);
    chk("fd_count_0", fd_cnt, 32'd0);

    // FEDCBA98 frame; 11111111 loaded mid-frame at tube 3.
    tick(8'h01, 8'hFE, 1'b1);
    chk("fd_count_1", fd_cnt, 32'd1);
    tick(8'h02, 8'hF6, 1'b0);
    tick(8'h04, 8'hEE, 1'b0);
    tick(8'h08, 8'h3E, 1'b0);
    do_load(32'h11111111, 8'h00, 8'h00);
    tick(8'h10, 8'h9C, 1'b0);
    tick(8'h20, 8'h7A, 1'b0);
    tick(8'h40, 8'h9E, 1'b0);
    tick(8'h80, 8'h8E, 1'b0);
    chk("fd_count_frame", fd_cnt, 32'd1);

    // All-ones frame; masks loaded at tube 1 take effect next frame.
    tick(8'h01, 8'h60, 1'b1);
    tick(8'h02, 8'h60, 1'b0);
    do_load(32'h11111111, 8'h04, 8'h05);
    tick(8'h04, 8'h60, 1'b0);
    tick(8'h08, 8'h60, 1'b0);
    tick(8'h10, 8'h60, 1'b0);
    tick(8'h20, 8'h60, 1'b0);
    tick(8'h40, 8'h60, 1'b0);
    tick(8'h80, 8'h60, 1'b0);
    tick(8'h01, 8'h61, 1'b1);
    tick(8'h02, 8'h60, 1'b0);
    tick(8'h04, 8'h00, 1'b0);
    chk("masked_seg", {24'd0, tub_seg}, 32'd0);
    tick(8'h08, 8'h60, 1'b0);
    tick(8'h10, 8'h60, 1'b0);
    tick(8'h20, 8'h60, 1'b0);

    // Drop enable on tube 5, then restart from tube 0.
    disp_en = 1'b0;
    cyc(1);
    chk("dis_sel", {24'd0, tub_sel}, 32'd0);
    chk("dis_seg", {24'd0, tub_seg}, 32'd0);
    cyc(3);
    chk("dis_hold", {24'd0, tub_sel}, 32'd0);
    enable_and_wait(8'h01, 8'h61);

    // Async reset between edges with a load still pending.
    do_load(32'h22222222, 8'h00, 8'hFF);
    cyc(3);
    #2;
    rst_n = 1'b0;
    disp_en = 1'b0;
    #1;
    chk("arst_sel", {24'd0, tub_sel}, 32'd0);
    chk("arst_seg", {24'd0, tub_seg}, 32'd0);
    chk("arst_fd", {31'd0, frame_done}, 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);
    chk("post_rst_dark", {24'd0, tub_sel}, 32'd0);
    enable_and_wait(8'h01, 8'hFC);
    tick(8'h02, 8'hFC, 1'b0);
    tick(8'h04, 8'hFC, 1'b0);
    tick(8'h08, 8'hFC, 1'b0);
    tick(8'h10, 8'hFC, 1'b0);
    tick(8'h20, 8'hFC, 1'b0);
    tick(8'h40, 8'hFC, 1'b0);
    tick(8'h80, 8'hFC, 1'b0);
    tick(8'h01, 8'hFC, 1'b1);
    cyc(2);
    chk("fd_count_end", fd_cnt, 32'd4);
    chk("queue_drained", expq.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
